// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode, funct, select and state encodings for the multicycle MIPS control unit
package mips_ctrl_pkg;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;
endpackage

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: decode inputs and datapath control outputs of the multicycle control unit
interface multicycle_control_unit_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       instr_done;
  logic       bad_op;
  logic [3:0] state;
  modport master (
    input  Op, Funct, Zero, mem_ready,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
           ALUControl, PCSrc, PCEn, instr_done, bad_op, state
  );
  modport slave (
    output Op, Funct, Zero, mem_ready,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
           ALUControl, PCSrc, PCEn, instr_done, bad_op, state
  );
endinterface

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: R-type funct to ALUControl, unknown funct falls back to add
module mc_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o
);
  always_comb
    alu_ctrl_o = funct_i == F_SUB ? ALU_SUB :
                 funct_i == F_AND ? ALU_AND :
                 funct_i == F_OR  ? ALU_OR  :
                 funct_i == F_SLT ? ALU_SLT : ALU_ADD;
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing a multicycle MIPS datapath with memory-ready waits
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input logic clk,
  input logic reset,
  multicycle_control_unit_if.master bus
);
  state_e state_q, state_d, cur;
  logic rdy;
  logic [2:0] rtype_alu, alu;
  logic [1:0] src_b, pc_src;
  logic iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, src_a, pc_en, done, bad;
  assign rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
  mc_alu_decoder u_alu_dec (.funct_i(bus.Funct), .alu_ctrl_o(rtype_alu));
  always_ff @(posedge clk)
    state_q <= reset ? S_FETCH : state_d;
  // reset shows FETCH selects; enables are masked separately below
  always_comb begin
    cur = reset ? S_FETCH : state_q;
    state_d = S_FETCH;
    iord = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    reg_write = 1'b0;
    src_a = 1'b0;
    src_b = SRCB_B;
    alu = ALU_ADD;
    pc_src = PC_ALU;
    pc_en = 1'b0;
    done = 1'b0;
    bad = 1'b0;
    case (cur)
      S_FETCH: begin
        src_b = SRCB_4;
        ir_write = rdy;
        pc_en = rdy;
        state_d = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        src_b = SRCB_IMMSH;
        state_d = (bus.Op == OP_LW || bus.Op == OP_SW) ? S_MEMADR :
                  bus.Op == OP_RTYPE ? S_RTYPEEX :
                  bus.Op == OP_BEQ   ? S_BEQEX   :
                  bus.Op == OP_ADDI  ? S_ADDIEX  :
                  bus.Op == OP_J     ? S_JEX     : S_FETCH;
        bad = state_d == S_FETCH;
      end
      S_MEMADR: begin
        src_a = 1'b1;
        src_b = SRCB_IMM;
        state_d = bus.Op == OP_SW ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        state_d = rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write = 1'b1;
        done = 1'b1;
      end
      S_MEMWR: begin
        iord = 1'b1;
        mem_write = 1'b1;
        done = rdy;
        state_d = rdy ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        src_a = 1'b1;
        alu = rtype_alu;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        reg_dst = 1'b1;
        reg_write = 1'b1;
        done = 1'b1;
      end
      S_BEQEX: begin
        src_a = 1'b1;
        alu = ALU_SUB;
        pc_src = PC_ALUOUT;
        pc_en = bus.Zero;
        done = 1'b1;
      end
      S_ADDIEX: begin
        src_a = 1'b1;
        src_b = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        done = 1'b1;
      end
      S_JEX: begin
        pc_src = PC_JUMP;
        pc_en = 1'b1;
        done = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end
  assign bus.IorD = iord;
  assign bus.RegDst = reg_dst;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.ALUSrcA = src_a;
  assign bus.ALUSrcB = src_b;
  assign bus.ALUControl = alu;
  assign bus.PCSrc = pc_src;
  assign bus.MemWrite = mem_write & ~reset;
  assign bus.IRWrite = ir_write & ~reset;
  assign bus.RegWrite = reg_write & ~reset;
  assign bus.PCEn = pc_en & ~reset;
  assign bus.instr_done = done & ~reset;
  assign bus.bad_op = bad & ~reset;
  assign bus.state = state_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed per-cycle checks of every control output against hand-written vectors
module tb_multicycle_control_unit;
  typedef logic [20:0] vec_t;
  // field order: state | IorD MemWrite IRWrite | RegDst MemtoReg RegWrite | ALUSrcA | ALUSrcB | ALUControl | PCSrc | PCEn instr_done bad_op
  localparam vec_t V_RST   = 21'b0000_000_000_0_01_010_00_000;
  localparam vec_t V_F1    = 21'b0000_001_000_0_01_010_00_100;
  localparam vec_t V_F0    = 21'b0000_000_000_0_01_010_00_000;
  localparam vec_t V_DEC   = 21'b0001_000_000_0_11_010_00_000;
  localparam vec_t V_DECB  = 21'b0001_000_000_0_11_010_00_001;
  localparam vec_t V_MADR  = 21'b0010_000_000_1_10_010_00_000;
  localparam vec_t V_MRD   = 21'b0011_100_000_0_00_010_00_000;
  localparam vec_t V_MWB   = 21'b0100_000_011_0_00_010_00_010;
  localparam vec_t V_MWR0  = 21'b0101_110_000_0_00_010_00_000;
  localparam vec_t V_MWR1  = 21'b0101_110_000_0_00_010_00_010;
  localparam vec_t V_RADD  = 21'b0110_000_000_1_00_010_00_000;
  localparam vec_t V_RSUB  = 21'b0110_000_000_1_00_110_00_000;
  localparam vec_t V_RWB   = 21'b0111_000_101_0_00_010_00_010;
  localparam vec_t V_BEQ1  = 21'b1000_000_000_1_00_110_01_110;
  localparam vec_t V_BEQ0  = 21'b1000_000_000_1_00_110_01_010;
  localparam vec_t V_AEX   = 21'b1001_000_000_1_10_010_00_000;
  localparam vec_t V_AWB   = 21'b1010_000_001_0_00_010_00_010;
  localparam vec_t V_JEX   = 21'b1011_000_000_0_00_010_10_110;
  localparam vec_t V_RSTRD = 21'b0011_000_000_0_01_010_00_000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  multicycle_control_unit_if bus ();
  multicycle_control_unit #(.MEM_WAIT_EN(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  wire vec_t obs = {bus.state, bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
                    bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.PCSrc, bus.PCEn,
                    bus.instr_done, bus.bad_op};
  task automatic test_reset();
    bus.Op = 6'd0;
    bus.Funct = 6'd0;
    bus.Zero = 1'b0;
    bus.mem_ready = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (obs !== V_RST) begin
        failures++;
        $display("FAIL reset_hold cyc%0d got=%b want=%b", i, obs, V_RST);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== V_F1) begin
      failures++;
      $display("FAIL reset_first_fetch got=%b want=%b", obs, V_F1);
    end
  endtask
  task automatic test_lw();
    vec_t e[5] = '{V_F1, V_DEC, V_MADR, V_MRD, V_MWB};
    bus.Op = 6'b100011;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = 1'b1;
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL lw cyc%0d got=%b want=%b", i, obs, e[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_rtype(input logic [5:0] funct, input vec_t ex, input string name);
    vec_t e[4] = '{V_F1, V_DEC, ex, V_RWB};
    bus.Op = 6'b000000;
    bus.Funct = funct;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL %s cyc%0d got=%b want=%b", name, i, obs, e[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_beq(input logic zero, input vec_t ex, input string name);
    vec_t e[3] = '{V_F1, V_DEC, ex};
    bus.Op = 6'b000100;
    bus.Zero = zero;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL %s cyc%0d got=%b want=%b", name, i, obs, e[i]);
      end
      @(posedge clk);
      #1;
    end
    bus.Zero = 1'b0;
  endtask
  task automatic test_sw_wait();
    vec_t e[6] = '{V_F1, V_DEC, V_MADR, V_MWR0, V_MWR0, V_MWR1};
    logic r[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    bus.Op = 6'b101011;
    for (int i = 0; i < 6; i++) begin
      bus.mem_ready = r[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL sw_wait cyc%0d got=%b want=%b", i, obs, e[i]);
      end
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b1;
  endtask
  task automatic test_addi_fetch_wait();
    vec_t e[5] = '{V_F0, V_F1, V_DEC, V_AEX, V_AWB};
    logic r[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bus.Op = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = r[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL addi_fetch_wait cyc%0d got=%b want=%b", i, obs, e[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_jump_bad_op();
    vec_t e[5] = '{V_F1, V_DEC, V_JEX, V_F1, V_DECB};
    logic [5:0] op[5] = '{6'b000010, 6'b000010, 6'b000010, 6'b111111, 6'b111111};
    for (int i = 0; i < 5; i++) begin
      bus.Op = op[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL jump_bad_op cyc%0d got=%b want=%b", i, obs, e[i]);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (obs !== V_F1) begin
      failures++;
      $display("FAIL bad_op_return got=%b want=%b", obs, V_F1);
    end
  endtask
  task automatic test_reset_mid_instr();
    vec_t e[3] = '{V_F1, V_DEC, V_MADR};
    bus.Op = 6'b100011;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL reset_mid_pre cyc%0d got=%b want=%b", i, obs, e[i]);
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== V_RSTRD) begin
      failures++;
      $display("FAIL reset_in_memrd got=%b want=%b", obs, V_RSTRD);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== V_F1) begin
      failures++;
      $display("FAIL reset_mid_after got=%b want=%b", obs, V_F1);
    end
  endtask
  initial begin
    test_reset();
    test_lw();
    test_rtype(6'b100000, V_RADD, "rtype_add");
    test_rtype(6'b100010, V_RSUB, "rtype_sub");
    test_beq(1'b1, V_BEQ1, "beq_taken");
    test_beq(1'b0, V_BEQ0, "beq_not_taken");
    test_sw_wait();
    test_addi_fetch_wait();
    test_jump_bad_op();
    test_reset_mid_instr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-style control FSM that sequences a multicycle MIPS datapath: shared instruction/data memory, instruction register, ALU reused for PC+4 and branch target.
- Replaces the single-cycle Control_Unit when the datapath moves to multicycle.
- Decodes Op/Funct, drives every mux select and write enable per cycle, and waits on a memory-ready handshake in memory states.

Parameters:
- MEM_WAIT_EN, 1, 1 = memory states hold until mem_ready; 0 = mem_ready ignored (treated as 1).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- Op  in  6  Instr[31:26] from instruction register
- Funct  in  6  Instr[5:0]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register load
- RegDst  out  1  A3 select: 1 = Instr[15:11], 0 = Instr[20:16]
- MemtoReg  out  1  WD3 select: 1 = Data register, 0 = ALUOut
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- PCEn  out  1  PC load = PCWrite | (Branch & Zero)
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- bad_op  out  1  one-cycle pulse in DECODE on an unsupported Op
- state  out  4  current state encoding, for debug

Behaviour:
- Reset:
  - Synchronous, active-high; the state register goes to FETCH.
  - While reset=1, all enables (MemWrite, IRWrite, RegWrite, PCEn), instr_done and bad_op are forced to 0.
  - While reset=1, selects take their FETCH values.
  - Reset asserted mid-instruction aborts it at the next edge; no partial write occurs after that edge.
- Outputs are a pure function of state, plus Zero (PCEn in BEQEX) and mem_ready. No output depends on Op or Funct except in DECODE (bad_op) and RTYPEEX (ALUControl).
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
  - RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11
- FETCH:
  - IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=add, PCSrc=00.
  - IRWrite=PCEn=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut).
  - Next state by Op:
    - 100011 lw / 101011 sw -> MEMADR
    - 000000 -> RTYPEEX
    - 000100 -> BEQEX
    - 001000 -> ADDIEX
    - 000010 -> JEX
    - any other Op -> FETCH with bad_op=1
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Next state FETCH.
- MEMWR:
  - IorD=1, MemWrite=1 every cycle while in the state (writes are idempotent).
  - Waits for mem_ready, then goes to FETCH with instr_done=1 in the completing cycle.
- RTYPEEX:
  - ALUSrcA=1, ALUSrcB=00.
  - ALUControl from Funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, any other Funct -> add.
  - Next state RTYPEWB.
- RTYPEWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Next state FETCH.
- BEQEX:
  - ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01.
  - PCEn=Zero, instr_done=1. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add. Next state ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Next state FETCH.
- JEX: PCSrc=10, PCEn=1, instr_done=1. Next state FETCH.
- Defaults: every output not listed for a state is 0 (ALUControl defaults to add). Unused encodings 12-15 return to FETCH.
- Cycle counts with mem_ready=1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, bad op 2.
- Each wait state (FETCH, MEMRD, MEMWR) adds one cycle per cycle of mem_ready=0.
- MEM_WAIT_EN=0: mem_ready is internally tied to 1.

Decomposition:
- Shared package mips_ctrl_pkg:
  - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - ALUControl encodings
  - ALUSrcB/PCSrc encodings
  - state encodings
- One sub-module, mc_alu_decoder: combinational Funct -> ALUControl, shared by RTYPEEX.

Test Plan:
- Reset held 3 cycles with mem_ready=1 -> all enables 0 during reset; state=0 after release; first FETCH has IRWrite=PCEn=1, ALUSrcB=01.
- lw 0x8C080004, mem_ready=1 -> state sequence 0,1,2,3,4; RegWrite=1, MemtoReg=1, RegDst=0 only in cycle 5; instr_done pulses once.
- add 0x01095020 then sub funct 100010 -> ALUControl=010 then 110 in RTYPEEX; RegDst=1, RegWrite=1 in RTYPEWB; 4 cycles each.
- beq, Zero=1 -> PCEn=1, PCSrc=01 in BEQEX. Repeat with Zero=0 -> PCEn=0. Both take 3 cycles.
- sw 0xAC080008 with mem_ready low 2 cycles in MEMWR -> MemWrite=1 for 3 cycles, then FETCH; 6 cycles total.
- Op=111111 -> bad_op=1 in DECODE, return to FETCH, no RegWrite/MemWrite. Reset asserted in MEMRD -> FETCH next cycle, no RegWrite.
